// File: rtl/md_position_pkg.sv
// Shared encodings for the position read path: dispatch/done commands and
// the batch engine state machine.
package md_position_pkg;

  localparam logic [1:0] DISP_HOLD   = 2'b00;
  localparam logic [1:0] DISP_GO     = 2'b01;
  localparam logic [1:0] DISP_REWIND = 2'b11;

  localparam logic [1:0] DONE_ALL    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_HALT
  } state_t;

endpackage

// File: rtl/position_read_unit_tag_pipe.sv
// Fixed-latency tag pipeline: carries {valid, last, cell, index} alongside
// each cache read so the tag emerges in the cycle the read data is valid.
module read_tag_pipe #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned CELL_W       = 2,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic [CELL_W-1:0] i_cell,
  input  logic [ADDR_W-1:0] i_index,
  output logic              o_valid,
  output logic              o_last,
  output logic [CELL_W-1:0] o_cell,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_busy
);

  logic [READ_LATENCY-1:0] r_valid;
  logic [READ_LATENCY-1:0] r_last;
  logic [CELL_W-1:0]       r_cell  [READ_LATENCY];
  logic [ADDR_W-1:0]       r_index [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_valid <= '0;
      r_last  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_last[k]  <= r_last[k-1];
      end
    end
  end

  // Tag payload needs no reset; it is qualified by r_valid.
  always_ff @(posedge clk) begin
    r_cell[0]  <= i_cell;
    r_index[0] <= i_index;
    for (int unsigned k = 1; k < READ_LATENCY; k++) begin
      r_cell[k]  <= r_cell[k-1];
      r_index[k] <= r_index[k-1];
    end
  end

  assign o_valid = r_valid[READ_LATENCY-1];
  assign o_last  = r_last[READ_LATENCY-1];
  assign o_cell  = r_cell[READ_LATENCY-1];
  assign o_index = r_index[READ_LATENCY-1];
  assign o_busy  = |r_valid;

endmodule

// File: rtl/position_read_unit.sv
// Batch engine: per dispatch, reads one particle slot across N_CELLS cells
// from the position cache and forwards occupied positions downstream.
module position_read_unit
  import md_position_pkg::*;
#(
  parameter int unsigned N_CELLS      = 4,
  parameter int unsigned CELL_W       = 2,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned POS_W        = 96,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        dispatch,
  input  logic [1:0]        done,
  input  logic [ADDR_W:0]   max_count,
  output logic              rd_en,
  output logic [CELL_W-1:0] rd_cell,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [POS_W-1:0]  rd_data,
  input  logic              rd_occ,
  output logic              out_valid,
  output logic [CELL_W-1:0] out_cell,
  output logic [ADDR_W-1:0] out_index,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_last,
  output logic              in_flight,
  output logic              finished_batch,
  output logic              finished_all
);

  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(N_CELLS - 1);
  localparam logic [ADDR_W:0]   MAX_SLOTS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W:0]   r_index;
  logic [ADDR_W:0]   r_count;
  logic [CELL_W-1:0] r_cell;
  logic              r_rd_en;
  logic              r_rd_last;
  logic [CELL_W-1:0] r_rd_cell;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_in_flight;
  logic              r_fin_batch;
  logic              r_fin_all;
  logic              r_out_valid;
  logic              r_out_last;
  logic [CELL_W-1:0] r_out_cell;
  logic [ADDR_W-1:0] r_out_index;
  logic [POS_W-1:0]  r_out_pos;

  logic              w_flush;
  logic [ADDR_W:0]   w_count_in;
  logic              w_tag_valid;
  logic              w_tag_last;
  logic [CELL_W-1:0] w_tag_cell;
  logic [ADDR_W-1:0] w_tag_index;
  logic              w_pipe_busy;

  assign w_flush    = reset || (dispatch == DISP_REWIND);
  assign w_count_in = (max_count > MAX_SLOTS) ? MAX_SLOTS : max_count;

  read_tag_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .CELL_W       (CELL_W),
    .ADDR_W       (ADDR_W)
  ) u_tag_pipe (
    .clk     (clk),
    .i_flush (w_flush),
    .i_valid (r_rd_en),
    .i_last  (r_rd_last),
    .i_cell  (r_rd_cell),
    .i_index (r_rd_addr),
    .o_valid (w_tag_valid),
    .o_last  (w_tag_last),
    .o_cell  (w_tag_cell),
    .o_index (w_tag_index),
    .o_busy  (w_pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_count     <= w_count_in;
      r_cell      <= '0;
      r_rd_en     <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_cell   <= '0;
      r_rd_addr   <= '0;
      r_in_flight <= 1'b0;
      r_fin_batch <= 1'b0;
      r_fin_all   <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (done == DONE_ALL) begin
            r_state <= ST_HALT;
          end else if (dispatch == DISP_GO) begin
            if (r_index < r_count) begin
              // Cell 0 is issued on the accepting edge so reads start at A+1.
              r_rd_en     <= 1'b1;
              r_rd_cell   <= '0;
              r_rd_addr   <= r_index[ADDR_W-1:0];
              r_rd_last   <= (N_CELLS == 1);
              r_cell      <= CELL_W'(1);
              r_state     <= (N_CELLS == 1) ? ST_DRAIN : ST_ISSUE;
              r_in_flight <= 1'b1;
              r_fin_batch <= 1'b0;
            end else begin
              r_fin_batch <= 1'b1;
              r_fin_all   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_rd_en   <= 1'b1;
          r_rd_cell <= r_cell;
          r_rd_last <= (r_cell == LAST_CELL);
          if (r_cell == LAST_CELL) begin
            r_state <= ST_DRAIN;
          end else begin
            r_cell <= r_cell + CELL_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!r_rd_en && !w_pipe_busy) begin
            r_state     <= ST_IDLE;
            r_index     <= r_index + IDX_ONE;
            r_in_flight <= 1'b0;
            r_fin_batch <= 1'b1;
            r_fin_all   <= ((r_index + IDX_ONE) == r_count);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // out_last marks the batch end even when the final slot is empty.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_cell  <= '0;
      r_out_index <= '0;
      r_out_pos   <= '0;
    end else begin
      r_out_valid <= w_tag_valid && rd_occ;
      r_out_last  <= w_tag_valid && w_tag_last;
      if (w_tag_valid) begin
        r_out_cell  <= w_tag_cell;
        r_out_index <= w_tag_index;
        r_out_pos   <= rd_data;
      end
    end
  end

  assign rd_en          = r_rd_en;
  assign rd_cell        = r_rd_cell;
  assign rd_addr        = r_rd_addr;
  assign out_valid      = r_out_valid;
  assign out_last       = r_out_last;
  assign out_cell       = r_out_cell;
  assign out_index      = r_out_index;
  assign out_pos        = r_out_pos;
  assign in_flight      = r_in_flight;
  assign finished_batch = r_fin_batch;
  assign finished_all   = r_fin_all;

endmodule

// File: doc/position_read_unit.md
# position_read_unit

Batch engine between the position read controller and the position cache. On each dispatch command it sweeps one particle-slot index across `N_CELLS` neighbouring cells and issues fixed-latency reads to the position cache. It forwards occupied positions to the filter bank and reports `in_flight`, `finished_batch` and `finished_all` back to the controller, which paces dispatches from those flags.

## Interface
- `N_CELLS`, 4: cells read per batch, one read per cell.
- `CELL_W`, 2: cell select width, $clog2(`N_CELLS`).
- `ADDR_W`, 8: particle-slot index width.
- `POS_W`, 96: packed x/y/z position, 3×32.
- `READ_LATENCY`, 2: cycles from `rd_en` to valid `rd_data`/`rd_occ`; minimum 1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `dispatch` in 2: 2'b01 run one batch, 2'b00 hold, 2'b11 rewind; 2'b10 is treated as hold.
- `done` in 2: 2'b01 means the sweep is complete, so freeze.
- `max_count` in ADDR_W+1: slots to sweep; latched during rewind.
- `rd_en` out 1: read strobe.
- `rd_cell` out CELL_W: cell being read.
- `rd_addr` out ADDR_W: slot index being read.
- `rd_data` in POS_W: returned position.
- `rd_occ` in 1: returned slot-occupied bit.
- `out_valid` out 1: output position valid.
- `out_cell` out CELL_W, `out_index` out ADDR_W, `out_pos` out POS_W: output tag and position.
- `out_last` out 1: marks the final read of the batch. It is asserted even when that slot is empty, with `out_valid`=0.
- `in_flight` out 1: batch reads issued or pending.
- `finished_batch` out 1: level flag, last batch fully drained.
- `finished_all` out 1: level flag, index reached `max_count`.

## Operation
- States are IDLE, ISSUE, DRAIN and HALT.
- Reset or `dispatch`==2'b11, in any state, forces the rewind values:
  - state IDLE, index 0, cell counter 0
  - pipeline flushed
  - all outputs 0 (`out_*`, `rd_*`, `in_flight`, `finished_*`)
  - `max_count` latched every rewind cycle.
- IDLE, `dispatch`==2'b01, index < latched count: accept the command. Next cycle go to ISSUE, set `in_flight`=1 and clear `finished_batch`.
- IDLE, `dispatch`==2'b01, index == latched count: accept with zero reads. Next cycle set `finished_batch`=1 and `finished_all`=1.
- `dispatch`==2'b01 is ignored outside IDLE. Duplicate dispatches from the controller are therefore harmless.
- ISSUE: one read per cycle with `rd_cell` = 0..N_CELLS-1 and `rd_addr` = index. After cell N_CELLS-1, go to DRAIN.
- A valid shift register tracks each read, tagged with cell, index and last. When a tag emerges, register the output: `out_valid` = `rd_occ`, `out_pos` = `rd_data`, plus the tag. Empty slots are dropped.
- DRAIN: wait until the pipeline is empty. Then, in one update, go to IDLE, set index to index+1, `in_flight`=0, `finished_batch`=1, and `finished_all` = (index+1 == latched count).
- `done`==2'b01 in IDLE: go to HALT. HALT ignores every dispatch except rewind. `done` outside IDLE is ignored.
- The index never wraps. It saturates at the latched count, maximum 2^ADDR_W.

## Timing
- Dispatch sampled at cycle A:
  - reads at A+1..A+N_CELLS
  - first output at A+1+READ_LATENCY+1
  - last output at A+N_CELLS+READ_LATENCY+1
  - `finished_batch`=1 and `in_flight`=0 at A+N_CELLS+READ_LATENCY+2
- Defaults (N_CELLS=4, READ_LATENCY=2): reads A+1..A+4, outputs A+4..A+7, finish at A+8.
- `in_flight` is registered and rises at A+1.
- All outputs are registered; there is no combinational input-to-output path.
- Outputs carry no backpressure; the consumer absorbs one position per cycle.
- Rewind mid-batch drops in-flight returns. No output appears after the rewind edge.

## Structure
- Shared package/include `md_position_pkg` holds:
  - dispatch encodings `DISP_HOLD`=2'b00, `DISP_GO`=2'b01, `DISP_REWIND`=2'b11
  - `DONE_ALL`=2'b01
  - state encodings
- Sub-module `read_tag_pipe`: parameterised `READ_LATENCY` shift register carrying {valid, last, cell, index}.

## Test plan
- Rewind with `max_count`=2, then GO at cycle A → reads at A+1..A+4 with addr 0, cells 0..3. Outputs at A+4..A+7 with `out_last` at A+7. `finished_batch`=1 at A+8, `finished_all`=0.
- Second GO → addr 1. At finish `finished_all`=1. A further GO does zero reads and `finished_batch` stays 1.
- `rd_occ`=0 for cell 2 → no `out_valid` at A+6. Other cells are still output.
- GO repeated on A+1 and A+2 → ignored, exactly 4 reads.
- `dispatch`=2'b11 at A+5 → no `out_valid` from A+6 onward. Index reads as 0 on the next batch.
- `max_count`=0 with GO → no `rd_en`. `finished_batch`=`finished_all`=1 one cycle later. Then `done`=01 → HALT, and a later GO is ignored.
